// File: rtl/fetch_exec_sequencer.sv
// Fetch/execute sequencer sitting on the consumer side of a combinational
// program ROM. It owns the program counter, fetches one 8-bit word per step
// and executes it on an 8-bit accumulator. A step takes two cycles (FETCH,
// EXEC). The sequencer stops when the ROM flags the end of the program, on a
// HALT opcode, or when the step watchdog expires.
//
// ROM handshake: the ROM is a pure combinational function of pc. pc only
// changes on the EXEC->FETCH edge, so word/HLT are stable for the whole FETCH
// cycle. HLT=1 means "word is valid". HLT=0 means "pc is past the end of the
// program"; the sequencer treats that as the end of the run.
module fetch_exec_sequencer #(
  parameter int PC_W      = 16,
  parameter int MAX_STEPS = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      word,
  input  logic            HLT,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      acc,
  output logic            carry,
  output logic [7:0]      out_data,
  output logic            out_valid,
  output logic            busy,
  output logic            halted,
  output logic            timeout,
  output logic [15:0]     step_count,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [3:0]  OP_LDI  = 4'h0;
  localparam logic [3:0]  OP_ADDI = 4'h1;
  localparam logic [3:0]  OP_SUBI = 4'h2;
  localparam logic [3:0]  OP_XORI = 4'h3;
  localparam logic [3:0]  OP_OUT  = 4'h4;
  localparam logic [3:0]  OP_JMP  = 4'h5;
  localparam logic [3:0]  OP_JZ   = 4'h6;
  localparam logic [3:0]  OP_HALT = 4'hF;
  localparam logic [15:0] STEP_LIMIT = 16'(MAX_STEPS);

  state_t          state, state_nx;
  logic [7:0]      ir, ir_nx;
  logic [PC_W-1:0] pc_nx;
  logic [7:0]      acc_nx, out_data_nx;
  logic            carry_nx, out_valid_nx, timeout_nx;
  logic [15:0]     step_nx;

  // Shared datapath terms for the EXEC step.
  logic [3:0]      opcode;
  logic [7:0]      imm;
  logic [8:0]      sum9, diff9;
  logic [PC_W-1:0] pc_inc, pc_target;
  logic [15:0]     step_inc;
  logic            limit_hit;

  assign opcode    = ir[7:4];
  assign imm       = {4'b0000, ir[3:0]};
  assign sum9      = {1'b0, acc} + {1'b0, imm};
  // Bit 8 of the 9-bit difference is the borrow (acc < imm).
  assign diff9     = {1'b0, acc} - {1'b0, imm};
  assign pc_inc    = pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign pc_target = PC_W'(ir[3:0]);
  assign step_inc  = (step_count == 16'hFFFF) ? step_count : step_count + 16'd1;
  assign limit_hit = (step_inc == STEP_LIMIT);

  assign busy      = (state == S_FETCH) || (state == S_EXEC);
  assign halted    = (state == S_HALTED);
  assign state_dbg = state;

  // All architectural state; reset wins over any write on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ir         <= 8'h00;
      pc         <= '0;
      acc        <= 8'h00;
      carry      <= 1'b0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      timeout    <= 1'b0;
      step_count <= 16'h0000;
    end else begin
      state      <= state_nx;
      ir         <= ir_nx;
      pc         <= pc_nx;
      acc        <= acc_nx;
      carry      <= carry_nx;
      out_data   <= out_data_nx;
      out_valid  <= out_valid_nx;
      timeout    <= timeout_nx;
      step_count <= step_nx;
    end
  end

  // Next-state and next-datapath decode; everything holds unless changed.
  always_comb begin
    state_nx     = state;
    ir_nx        = ir;
    pc_nx        = pc;
    acc_nx       = acc;
    carry_nx     = carry;
    out_data_nx  = out_data;
    out_valid_nx = 1'b0;
    timeout_nx   = timeout;
    step_nx      = step_count;
    case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_nx   = S_FETCH;
          pc_nx      = '0;
          acc_nx     = 8'h00;
          carry_nx   = 1'b0;
          step_nx    = 16'h0000;
          timeout_nx = 1'b0;
        end
      end
      S_FETCH: begin
        if (!HLT) begin
          state_nx = S_HALTED;
        end else begin
          ir_nx    = word;
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        step_nx  = step_inc;
        pc_nx    = pc_inc;
        state_nx = S_FETCH;
        case (opcode)
          OP_LDI:  acc_nx = imm;
          OP_ADDI: {carry_nx, acc_nx} = sum9;
          OP_SUBI: begin
            acc_nx   = diff9[7:0];
            carry_nx = diff9[8];
          end
          OP_XORI: acc_nx = acc ^ imm;
          OP_OUT: begin
            out_data_nx  = acc;
            out_valid_nx = 1'b1;
          end
          OP_JMP:  pc_nx = pc_target;
          OP_JZ:   if (acc == 8'h00) pc_nx = pc_target;
          OP_HALT: pc_nx = pc;
          default: ;
        endcase
        // A HALT landing on the watchdog limit is a clean halt, not a timeout.
        if (opcode == OP_HALT) begin
          state_nx = S_HALTED;
        end else if (limit_hit) begin
          state_nx   = S_HALTED;
          timeout_nx = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Bench for fetch_exec_sequencer: one instance with the default watchdog runs
// the functional programs, a second with MAX_STEPS=8 exercises the watchdog.
module tb_fetch_exec_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start, wd_start;

  // ---------------- main DUT + ROM model ----------------
  logic [7:0]  word;
  logic        hlt;
  logic [15:0] pc;
  logic [7:0]  acc, out_data;
  logic        carry, out_valid, busy, halted, timeout;
  logic [15:0] step_count;
  logic [1:0]  state_dbg;

  logic [7:0]  rom [0:31];
  int          rom_len;

  assign hlt  = (int'(pc) < rom_len);
  assign word = hlt ? rom[pc[4:0]] : 8'h00;

  fetch_exec_sequencer #(.PC_W(16), .MAX_STEPS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .word(word), .HLT(hlt),
    .pc(pc), .acc(acc), .carry(carry), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .halted(halted), .timeout(timeout),
    .step_count(step_count), .state_dbg(state_dbg)
  );

  // ---------------- watchdog DUT + ROM model ----------------
  logic [7:0]  wd_word;
  logic        wd_hlt;
  logic [15:0] wd_pc;
  logic [7:0]  wd_acc, wd_out_data;
  logic        wd_carry, wd_out_valid, wd_busy, wd_halted, wd_timeout;
  logic [15:0] wd_step_count;
  logic [1:0]  wd_state_dbg;

  logic [7:0]  wd_rom [0:7];
  int          wd_len;

  assign wd_hlt  = (int'(wd_pc) < wd_len);
  assign wd_word = wd_hlt ? wd_rom[wd_pc[2:0]] : 8'h00;

  fetch_exec_sequencer #(.PC_W(16), .MAX_STEPS(8)) dut_wd (
    .clk(clk), .rst(rst), .start(wd_start), .word(wd_word), .HLT(wd_hlt),
    .pc(wd_pc), .acc(wd_acc), .carry(wd_carry), .out_data(wd_out_data),
    .out_valid(wd_out_valid), .busy(wd_busy), .halted(wd_halted),
    .timeout(wd_timeout), .step_count(wd_step_count), .state_dbg(wd_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_out_q [$];   // expected out_data per out_valid pulse
  logic [49:0] exp_halt_q [$];  // {pc, acc, carry, timeout, step_count, out_data}
  logic [41:0] exp_wd_q [$];    // {pc, acc, carry, timeout, step_count}

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endfunction

  // Main monitor: pops on every out_valid pulse and on every entry to HALTED.
  logic prev_ov = 1'b0, prev_halted = 1'b0;
  always @(negedge clk) begin
    if (out_valid) begin
      check("out_valid_spacing", {63'b0, prev_ov}, 64'd0);
      if (exp_out_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: out_valid with data 0x%0h, none expected", out_data);
      end else begin
        check("out_data", {56'b0, out_data}, {56'b0, exp_out_q.pop_front()});
      end
    end
    if (halted && !prev_halted) begin
      if (exp_halt_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL halt_unexpected: halted at pc 0x%0h, none expected", pc);
      end else begin
        check("halt_record", {14'b0, pc, acc, carry, timeout, step_count, out_data},
              {14'b0, exp_halt_q.pop_front()});
      end
    end
    prev_ov     <= out_valid;
    prev_halted <= halted;
  end

  // Watchdog monitor.
  logic prev_wd_halted = 1'b0;
  always @(negedge clk) begin
    if (wd_out_valid) begin
      checks++;
      errors++;
      $display("FAIL wd_out_unexpected: out_valid with data 0x%0h, none expected", wd_out_data);
    end
    if (wd_halted && !prev_wd_halted) begin
      check("wd_state_halted", {62'b0, wd_state_dbg}, 64'd3);
      check("wd_busy_low", {63'b0, wd_busy}, 64'd0);
      if (exp_wd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wd_halt_unexpected: halted at pc 0x%0h, none expected", wd_pc);
      end else begin
        check("wd_halt_record", {22'b0, wd_pc, wd_acc, wd_carry, wd_timeout, wd_step_count},
              {22'b0, exp_wd_q.pop_front()});
      end
    end
    prev_wd_halted <= wd_halted;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_roms();
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    for (int i = 0; i < 8; i++) wd_rom[i] = 8'h00;
  endtask

  // Pulse start, wait (bounded) for HALTED; optionally pokes start while busy.
  task automatic run_main(input bit poke, input int exp_cycles);
    int n;
    bit done;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk);
      n++;
      #1 start = (poke && n == 3);
      if (halted) done = 1'b1;
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL main_halt_timeout: not halted after %0d cycles, required halt", n);
    end else if (exp_cycles > 0) begin
      check("start_to_halt_cycles", 64'(n), 64'(exp_cycles));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_wd(input int exp_cycles);
    int n;
    bit done;
    @(posedge clk); #1 wd_start = 1'b1;
    @(posedge clk); #1 wd_start = 1'b0;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (wd_halted) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wd_halt_timeout: not halted after %0d cycles, required halt", n);
    end else begin
      check("wd_start_to_halt_cycles", 64'(n), 64'(exp_cycles));
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0;
    wd_start = 1'b0;
    rom_len = 0;
    wd_len = 0;
    clear_roms();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state",
          {pc, acc, carry, out_data, out_valid, busy, halted, timeout, step_count, state_dbg},
          64'd0);
    rst = 1'b0;

    // T1: LDI 2, ADDI 13, SUBI 8, OUT -> 7; end of ROM at pc 4.
    rom[0] = 8'h02; rom[1] = 8'h1D; rom[2] = 8'h28; rom[3] = 8'h40; rom_len = 4;
    exp_out_q.push_back(8'h07);
    exp_halt_q.push_back({16'd4, 8'h07, 1'b0, 1'b0, 16'd4, 8'h07});
    run_main(1'b0, 9);

    // T2: LDI 3, SUBI 9 -> 0xFA with borrow, OUT.
    clear_roms();
    rom[0] = 8'h03; rom[1] = 8'h29; rom[2] = 8'h40; rom_len = 3;
    exp_out_q.push_back(8'hFA);
    exp_halt_q.push_back({16'd3, 8'hFA, 1'b1, 1'b0, 16'd3, 8'hFA});
    run_main(1'b0, 7);

    // T3: LDI 15 then 17x ADDI 15 -> 270 mod 256 = 0x0E, carry on last step.
    // A start pulse mid-run must be ignored.
    clear_roms();
    rom[0] = 8'h0F;
    for (int i = 1; i <= 17; i++) rom[i] = 8'h1F;
    rom_len = 18;
    exp_halt_q.push_back({16'd18, 8'h0E, 1'b1, 1'b0, 16'd18, 8'hFA});
    run_main(1'b1, 37);

    // T4: LDI 1, SUBI 1, JZ 4, JMP 0, HALT -> HALT executed at pc 4.
    clear_roms();
    rom[0] = 8'h01; rom[1] = 8'h21; rom[2] = 8'h64; rom[3] = 8'h50; rom[4] = 8'hF0;
    rom_len = 5;
    exp_halt_q.push_back({16'd4, 8'h00, 1'b0, 1'b0, 16'd4, 8'hFA});
    run_main(1'b0, 8);

    // T5: reset lands on the EXEC of an OUT -> no pulse, everything cleared.
    clear_roms();
    rom[0] = 8'h05; rom[1] = 8'h40; rom[2] = 8'hF0; rom_len = 3;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("reset_mid_exec",
          {pc, acc, carry, out_data, out_valid, busy, halted, timeout, step_count, state_dbg},
          64'd0);
    @(negedge clk);
    check("idle_after_reset", {62'b0, state_dbg}, 64'd0);
    exp_out_q.push_back(8'h05);
    exp_halt_q.push_back({16'd2, 8'h05, 1'b0, 1'b0, 16'd3, 8'h05});
    run_main(1'b0, 6);

    // T6: JMP 0 forever with MAX_STEPS=8 -> watchdog halt.
    wd_rom[0] = 8'h50; wd_len = 1;
    exp_wd_q.push_back({16'd0, 8'h00, 1'b0, 1'b1, 16'd8});
    run_wd(16);

    // T7: 7 NOPs then HALT as the 8th step -> HALT wins, no timeout.
    for (int i = 0; i < 7; i++) wd_rom[i] = 8'h70;
    wd_rom[7] = 8'hF0; wd_len = 8;
    exp_wd_q.push_back({16'd7, 8'h00, 1'b0, 1'b0, 16'd8});
    run_wd(16);

    repeat (3) @(negedge clk);
    check("out_q_drained", 64'(exp_out_q.size()), 64'd0);
    check("halt_q_drained", 64'(exp_halt_q.size()), 64'd0);
    check("wd_q_drained", 64'(exp_wd_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
